// File: rtl/pkg_parameters.sv
// Shared widths, frame geometry defaults and the fill/full state type for the
// feature-map buffer.
package pkg_parameters;

    localparam int FEATURE_MAP_RESOLUTION = 8;
    localparam int FEATURE_MAP_ADDRWIDE   = 9;

    localparam int REC_IMG_W_DEFAULT = 29;
    localparam int REC_IMG_H_DEFAULT = 13;
    localparam int FMAP_PIXELS       = REC_IMG_W_DEFAULT * REC_IMG_H_DEFAULT;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fmap_state_t;

endpackage

// File: rtl/fmap_ram.sv
// Simple dual-port pixel store: one write port, one registered read port.
// Contents are deliberately not reset.
module fmap_ram #(
    parameter int DEPTH = 377,
    parameter int WIDTH = 8,
    parameter int AW    = 9
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fmap_buffer.sv
// Single-frame feature-map buffer: fills from the quantizer stream, then serves
// random reads until the consumer releases it. Define FMAP_BUF_ADDR_CHECK_EN for
// the sticky out-of-range address flag.
module fmap_buffer
    import pkg_parameters::*;
#(
    parameter int REC_IMG_W = REC_IMG_W_DEFAULT,
    parameter int REC_IMG_H = REC_IMG_H_DEFAULT
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              mqcRec_valid_i,
    input  logic [FEATURE_MAP_RESOLUTION-1:0] mqcRec_data_i,
    input  logic [FEATURE_MAP_ADDRWIDE-1:0]   mqcRec_addr_i,
    output logic                              mqcRec_ready_o,
    output logic                              frame_full_o,
    input  logic                              rd_en_i,
    input  logic [FEATURE_MAP_ADDRWIDE-1:0]   rd_addr_i,
    output logic                              rd_valid_o,
    output logic [FEATURE_MAP_RESOLUTION-1:0] rd_data_o,
    input  logic                              rd_done_i,
    output logic [FEATURE_MAP_ADDRWIDE:0]     fill_cnt_o,
    output logic                              addr_err_o
);

    localparam int AW  = FEATURE_MAP_ADDRWIDE;
    localparam int DW  = FEATURE_MAP_RESOLUTION;
    localparam int PIX = REC_IMG_W * REC_IMG_H;
    localparam logic [AW:0] PIX_CNT = (AW + 1)'(PIX);

    fmap_state_t state_q, state_d;
    logic [AW:0] fill_cnt_q, fill_cnt_d;
    logic        ready_q, ready_d;
    logic        rd_valid_q, rd_valid_d;
    logic        rd_oob_q, rd_oob_d;
    logic        wr_in_range, rd_in_range;
    logic        wr_accept, rd_fire;
    logic [DW-1:0] ram_rdata;

    assign wr_in_range = {1'b0, mqcRec_addr_i} < PIX_CNT;
    assign rd_in_range = {1'b0, rd_addr_i} < PIX_CNT;
    assign wr_accept   = mqcRec_valid_i && ready_q && wr_in_range;
    assign rd_fire     = rd_en_i && (state_q == FULL);

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        rd_valid_d = 1'b0;
        rd_oob_d   = 1'b0;
        if (state_q == FILL) begin
            if (wr_accept) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_q == PIX_CNT - 1'b1) begin
                    state_d = FULL;
                end
            end
        end else begin
            // a read issued alongside the release is still served
            rd_valid_d = rd_en_i;
            rd_oob_d   = rd_en_i && !rd_in_range;
            if (rd_done_i) begin
                state_d    = FILL;
                fill_cnt_d = '0;
            end
        end
        ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            ready_q    <= ready_d;
            rd_valid_q <= rd_valid_d;
            rd_oob_q   <= rd_oob_d;
        end
    end

`ifdef FMAP_BUF_ADDR_CHECK_EN
    logic addr_err_q, addr_err_d;

    always_comb begin
        addr_err_d = addr_err_q;
        if ((mqcRec_valid_i && ready_q && !wr_in_range) || (rd_fire && !rd_in_range)) begin
            addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err_o = addr_err_q;
`else
    assign addr_err_o = 1'b0;
`endif

    fmap_ram #(
        .DEPTH (PIX),
        .WIDTH (DW),
        .AW    (AW)
    ) u_fmap_ram (
        .clk_i   (clk_i),
        .we_i    (wr_accept),
        .waddr_i (mqcRec_addr_i),
        .wdata_i (mqcRec_data_i),
        .re_i    (rd_fire && rd_in_range),
        .raddr_i (rd_addr_i),
        .rdata_o (ram_rdata)
    );

    assign mqcRec_ready_o = ready_q;
    assign frame_full_o   = (state_q == FULL);
    assign fill_cnt_o     = fill_cnt_q;
    assign rd_valid_o     = rd_valid_q;
    assign rd_data_o      = (rd_valid_q && !rd_oob_q) ? ram_rdata : '0;

endmodule
